// File: rtl/led_ctrl_pkg.sv
// Shared types and helpers for the LED bar pattern controller.
package led_ctrl_pkg;

    // Widest LED bar the helper functions can describe; N_LED must not exceed it.
    localparam int LED_MAX = 32;

    typedef enum logic [1:0] {
        CHASE_L = 2'd0,
        CHASE_R = 2'd1,
        BOUNCE  = 2'd2,
        BLINK   = 2'd3
    } mode_e;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        LOAD  = 2'd1,
        RUN   = 2'd2,
        PAUSE = 2'd3
    } state_e;

    typedef enum logic {
        UP   = 1'b0,
        DOWN = 1'b1
    } dir_e;

    // Starting pattern of each mode, LSB-aligned; callers size-cast to N_LED bits.
    function automatic logic [LED_MAX-1:0] init_pattern(input mode_e mode, input int n_led);
        logic [LED_MAX-1:0] p;
        p = '0;
        case (mode)
            CHASE_L: p[0] = 1'b1;
            CHASE_R: p[n_led-1] = 1'b1;
            BOUNCE:  p[0] = 1'b1;
            BLINK: begin
                for (int i = 0; i < LED_MAX; i++) begin
                    if (i < n_led) p[i] = 1'b1;
                end
            end
            default: p = '0;
        endcase
        return p;
    endfunction

    // Mode cycling wraps from BLINK back to CHASE_L.
    function automatic mode_e next_mode(input mode_e mode);
        return mode_e'(mode + 2'd1);
    endfunction

endpackage

// File: rtl/led_step_timer.sv
// Step-rate timer: counts enabled cycles and raises tick when the
// speed-dependent period has elapsed. The period is re-evaluated every cycle,
// so a speed change applies immediately to the running count.
module led_step_timer
    import led_ctrl_pkg::*;
#(
    parameter int BASE_DIV = 25000000,
    parameter int CNT_W    = 32
) (
    input  logic       clk,
    input  logic       rstn,
    input  logic       i_enable,
    input  logic       i_clear,
    input  logic [1:0] i_speed,
    output logic       o_tick
);

    localparam logic [CNT_W-1:0] BASE = CNT_W'(BASE_DIV);

    logic [CNT_W-1:0] r_cnt;
    logic [CNT_W-1:0] w_shift;
    logic [CNT_W-1:0] w_period;
    logic             w_tick;

    // Period = BASE_DIV >> speed, clamped to at least one cycle.
    always_comb begin
        w_shift  = BASE >> i_speed;
        w_period = (w_shift == '0) ? CNT_W'(1) : w_shift;
    end

    // ">=" rather than "==" so a count already past a shortened period ticks at once.
    assign w_tick = i_enable && (r_cnt >= (w_period - CNT_W'(1)));
    assign o_tick = w_tick;

    // Counter: cleared on load, frozen while disabled, restarts after each tick.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_cnt <= '0;
        end else if (i_clear) begin
            r_cnt <= '0;
        end else if (i_enable) begin
            if (w_tick) r_cnt <= '0;
            else        r_cnt <= r_cnt + CNT_W'(1);
        end
    end

endmodule

// File: rtl/led_pattern_ctrl.sv
// LED bar pattern controller: sequences four animation modes at a
// programmable step rate with run/pause control and mode cycling.
// Control handshake: run_i is a level sampled every cycle; mode_next_i is a
// one-cycle pulse acted on in the cycle it is high (no ready/back-pressure).
module led_pattern_ctrl
    import led_ctrl_pkg::*;
#(
    parameter int N_LED    = 10,
    parameter int BASE_DIV = 25000000,
    parameter int CNT_W    = 32
) (
    input  logic             clk,
    input  logic             rstn,
    input  logic             run_i,
    input  logic             mode_next_i,
    input  logic [1:0]       speed_i,
    output logic [N_LED-1:0] led_o,
    output logic [1:0]       mode_o,
    output logic             step_o
);

    state_e           r_state;
    mode_e            r_mode;
    dir_e             r_dir;
    logic [N_LED-1:0] r_led;
    logic             r_step;

    state_e           w_state_nxt;
    mode_e            w_mode_nxt;
    dir_e             w_dir_nxt;
    logic [N_LED-1:0] w_led_nxt;
    logic             w_step_nxt;

    logic [N_LED-1:0] w_init;
    logic [N_LED-1:0] w_step_led;
    dir_e             w_step_dir;
    logic             w_tick;
    logic             w_timer_en;
    logic             w_timer_clr;

    assign w_init = N_LED'(init_pattern(r_mode, N_LED));

    // The counter only advances in cycles whose tick could actually be used;
    // leaving RUN or switching mode freezes it, so a pause resumes mid-count.
    assign w_timer_en  = (r_state == RUN) && run_i && !mode_next_i;
    assign w_timer_clr = (r_state == LOAD);

    led_step_timer #(
        .BASE_DIV (BASE_DIV),
        .CNT_W    (CNT_W)
    ) u_timer (
        .clk      (clk),
        .rstn     (rstn),
        .i_enable (w_timer_en),
        .i_clear  (w_timer_clr),
        .i_speed  (speed_i),
        .o_tick   (w_tick)
    );

    // Next pattern and bounce direction for one animation step of the current mode.
    always_comb begin
        w_step_led = r_led;
        w_step_dir = r_dir;
        case (r_mode)
            CHASE_L: begin
                if (r_led == '0) w_step_led = w_init;
                else             w_step_led = {r_led[N_LED-2:0], r_led[N_LED-1]};
            end
            CHASE_R: begin
                if (r_led == '0) w_step_led = w_init;
                else             w_step_led = {r_led[0], r_led[N_LED-1:1]};
            end
            BOUNCE: begin
                if (r_led == '0) begin
                    w_step_led = w_init;
                    w_step_dir = UP;
                end else if (r_dir == UP) begin
                    if (r_led[N_LED-1]) begin
                        w_step_dir = DOWN;
                        w_step_led = r_led >> 1;
                    end else begin
                        w_step_led = r_led << 1;
                    end
                end else begin
                    if (r_led[0]) begin
                        w_step_dir = UP;
                        w_step_led = r_led << 1;
                    end else begin
                        w_step_led = r_led >> 1;
                    end
                end
            end
            BLINK:   w_step_led = ~r_led;
            default: w_step_led = r_led;
        endcase
    end

    // FSM next state and datapath updates; mode_next_i outranks run_i and ticks.
    always_comb begin
        w_state_nxt = r_state;
        w_mode_nxt  = r_mode;
        w_dir_nxt   = r_dir;
        w_led_nxt   = r_led;
        w_step_nxt  = 1'b0;
        case (r_state)
            IDLE: begin
                w_led_nxt = '0;
                if (mode_next_i)  w_mode_nxt  = next_mode(r_mode);
                else if (run_i)   w_state_nxt = LOAD;
            end
            LOAD: begin
                w_led_nxt = w_init;
                w_dir_nxt = UP;
                if (mode_next_i) begin
                    w_mode_nxt  = next_mode(r_mode);
                    w_state_nxt = LOAD;
                end else begin
                    w_state_nxt = run_i ? RUN : PAUSE;
                end
            end
            RUN: begin
                if (mode_next_i) begin
                    w_mode_nxt  = next_mode(r_mode);
                    w_state_nxt = LOAD;
                end else if (!run_i) begin
                    w_state_nxt = PAUSE;
                end else if (w_tick) begin
                    w_led_nxt  = w_step_led;
                    w_dir_nxt  = w_step_dir;
                    w_step_nxt = 1'b1;
                end
            end
            PAUSE: begin
                if (mode_next_i) begin
                    w_mode_nxt  = next_mode(r_mode);
                    w_state_nxt = LOAD;
                end else if (run_i) begin
                    w_state_nxt = RUN;
                end
            end
            default: w_state_nxt = IDLE;
        endcase
    end

    // State and output registers.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_state <= IDLE;
            r_mode  <= CHASE_L;
            r_dir   <= UP;
            r_led   <= '0;
            r_step  <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_mode  <= w_mode_nxt;
            r_dir   <= w_dir_nxt;
            r_led   <= w_led_nxt;
            r_step  <= w_step_nxt;
        end
    end

    assign led_o  = r_led;
    assign mode_o = r_mode;
    assign step_o = r_step;

endmodule

// File: tb/tb_led_pattern_ctrl.sv
// Directed bench for led_pattern_ctrl with BASE_DIV = 4.
module tb_led_pattern_ctrl;

    logic       clk;
    logic       rstn;
    logic       run_i;
    logic       mode_next_i;
    logic [1:0] speed_i;
    logic [9:0] led_o;
    logic [1:0] mode_o;
    logic       step_o;

    int errors = 0;
    int checks = 0;

    logic [9:0] bounce_seq [19] = '{10'h002, 10'h004, 10'h008, 10'h010, 10'h020,
                                    10'h040, 10'h080, 10'h100, 10'h200, 10'h100,
                                    10'h080, 10'h040, 10'h020, 10'h010, 10'h008,
                                    10'h004, 10'h002, 10'h001, 10'h002};

    led_pattern_ctrl #(
        .N_LED    (10),
        .BASE_DIV (4),
        .CNT_W    (32)
    ) dut (
        .clk         (clk),
        .rstn        (rstn),
        .run_i       (run_i),
        .mode_next_i (mode_next_i),
        .speed_i     (speed_i),
        .led_o       (led_o),
        .mode_o      (mode_o),
        .step_o      (step_o)
    );

    // Clock: 10 time units per cycle.
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Advance one clock edge; inputs are driven and outputs sampled 1 unit after it.
    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Hold prev for gap-1 cycles without step_o, then expect nxt with a step_o pulse.
    task automatic run_step(input string tag, input logic [9:0] prev,
                            input logic [9:0] nxt, input int gap);
        for (int i = 0; i < gap - 1; i++) begin
            cyc();
            chk({tag, "_hold"}, 32'(led_o), 32'(prev));
            chk({tag, "_nostep"}, 32'(step_o), 32'd0);
        end
        cyc();
        chk({tag, "_led"}, 32'(led_o), 32'(nxt));
        chk({tag, "_step"}, 32'(step_o), 32'd1);
    endtask

    // Single mode_next_i pulse, then the LOAD cycle.
    task automatic next_mode_load(input string tag, input logic [1:0] exp_mode,
                                  input logic [9:0] exp_led);
        mode_next_i = 1'b1;
        cyc();
        mode_next_i = 1'b0;
        chk({tag, "_mode"}, 32'(mode_o), 32'(exp_mode));
        cyc();
        chk({tag, "_load_led"}, 32'(led_o), 32'(exp_led));
        chk({tag, "_load_nostep"}, 32'(step_o), 32'd0);
    endtask

    initial begin
        rstn        = 1'b0;
        run_i       = 1'b0;
        mode_next_i = 1'b0;
        speed_i     = 2'd0;
        repeat (3) cyc();
        chk("rst_led", 32'(led_o), 32'd0);
        chk("rst_mode", 32'(mode_o), 32'd0);
        chk("rst_step", 32'(step_o), 32'd0);

        // 1: chase left from LOAD through the wrap.
        rstn  = 1'b1;
        run_i = 1'b1;
        cyc();
        chk("idle_led", 32'(led_o), 32'd0);
        cyc();
        chk("load_led", 32'(led_o), 32'h001);
        chk("load_nostep", 32'(step_o), 32'd0);
        for (int k = 1; k < 10; k++) run_step("chase_l", 10'(1 << (k - 1)), 10'(1 << k), 4);
        run_step("chase_l_wrap", 10'h200, 10'h001, 4);

        // 2: two mode pulses to BOUNCE, then a full bounce plus one.
        next_mode_load("to_chase_r", 2'd1, 10'h200);
        next_mode_load("to_bounce", 2'd2, 10'h001);
        run_step("bounce0", 10'h001, bounce_seq[0], 4);
        for (int k = 1; k < 19; k++) run_step("bounce", bounce_seq[k-1], bounce_seq[k], 4);

        // 3: speed changes (bounce now at 0x002, going up).
        speed_i = 2'd2;
        run_step("spd2_a", 10'h002, 10'h004, 1);
        run_step("spd2_b", 10'h004, 10'h008, 1);
        speed_i = 2'd3;
        run_step("spd3_a", 10'h008, 10'h010, 1);
        run_step("spd3_b", 10'h010, 10'h020, 1);
        speed_i = 2'd0;
        run_step("spd0", 10'h020, 10'h040, 4);
        cyc();
        cyc();
        chk("midcnt_hold", 32'(led_o), 32'h040);
        speed_i = 2'd2;
        cyc();
        chk("midcnt_led", 32'(led_o), 32'h080);
        chk("midcnt_step", 32'(step_o), 32'd1);
        speed_i = 2'd0;

        // 4: pause two cycles after a step, then resume.
        cyc();
        cyc();
        run_i = 1'b0;
        for (int i = 0; i < 10; i++) begin
            cyc();
            chk("pause_led", 32'(led_o), 32'h080);
            chk("pause_nostep", 32'(step_o), 32'd0);
        end
        run_i = 1'b1;
        run_step("resume", 10'h080, 10'h100, 3);

        // BLINK and CHASE_L, then into CHASE_R.
        next_mode_load("to_blink", 2'd3, 10'h3FF);
        run_step("blink_a", 10'h3FF, 10'h000, 4);
        run_step("blink_b", 10'h000, 10'h3FF, 4);
        next_mode_load("to_chase_l", 2'd0, 10'h001);
        next_mode_load("to_chase_r2", 2'd1, 10'h200);
        run_step("chase_r", 10'h200, 10'h100, 4);

        // 5: mode pulse coinciding with a tick in CHASE_R.
        cyc();
        cyc();
        cyc();
        chk("pre_tick_led", 32'(led_o), 32'h100);
        mode_next_i = 1'b1;
        cyc();
        mode_next_i = 1'b0;
        chk("drop_mode", 32'(mode_o), 32'd2);
        chk("drop_led", 32'(led_o), 32'h100);
        chk("drop_nostep", 32'(step_o), 32'd0);
        cyc();
        chk("drop_load_led", 32'(led_o), 32'h001);
        chk("drop_load_nostep", 32'(step_o), 32'd0);

        // 6: asynchronous reset mid-cycle while in BLINK, right after a step.
        next_mode_load("to_blink2", 2'd3, 10'h3FF);
        run_step("blink_c", 10'h3FF, 10'h000, 4);
        run_step("blink_d", 10'h000, 10'h3FF, 4);
        #2;
        rstn = 1'b0;
        #1;
        chk("async_led", 32'(led_o), 32'd0);
        chk("async_mode", 32'(mode_o), 32'd0);
        chk("async_step", 32'(step_o), 32'd0);
        cyc();
        cyc();
        rstn = 1'b1;
        cyc();
        chk("restart_idle_led", 32'(led_o), 32'd0);
        cyc();
        chk("restart_load_led", 32'(led_o), 32'h001);
        run_step("restart", 10'h001, 10'h002, 4);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
